// File: rtl/reg_wb_pkg.sv
// Shared constants for the register-file writeback arbiter: port widths and requester indices.
package reg_wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/wb_hold_slot.sv
// One-entry valid/ready holding register; drain and reload may happen on the same edge.
module wb_hold_slot
    import reg_wb_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          drain_i,
    output logic          ready_o,
    output logic          hold_v_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);
    logic          hold_v_q, hold_v_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          load;

    assign ready_o = ~hold_v_q | drain_i;
    assign load    = load_valid_i & ready_o;

    always_comb begin
        hold_v_d = hold_v_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (load) begin
            hold_v_d = 1'b1;
            addr_d   = load_addr_i;
            data_d   = load_data_i;
        end else if (drain_i) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign hold_v_o = hold_v_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file write port between ALU and load writeback, with a busy scoreboard.
// Define WB_RR_ARB_EN for round-robin arbitration; default is fixed priority (mem over alu).
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W,
    parameter int NR = NREG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          claim_valid,
    input  logic [AW-1:0] claim_addr,
    output logic          wr,
    output logic [AW-1:0] addr3,
    output logic [DW-1:0] data3,
    output logic [NR-1:0] busy_mask
);
    logic          alu_hv, mem_hv;
    logic [AW-1:0] alu_haddr, mem_haddr;
    logic [DW-1:0] alu_hdata, mem_hdata;
    logic          grant_alu, grant_mem, any_grant, mem_wins;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gdata;

    logic          wr_q, wr_d;
    logic [AW-1:0] addr3_q, addr3_d;
    logic [DW-1:0] data3_q, data3_d;
    logic [NR-1:0] busy_q, busy_d;

    wb_hold_slot #(.DW(DW), .AW(AW)) u_alu_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (alu_valid),
        .load_addr_i  (alu_addr),
        .load_data_i  (alu_data),
        .drain_i      (grant_alu),
        .ready_o      (alu_ready),
        .hold_v_o     (alu_hv),
        .addr_o       (alu_haddr),
        .data_o       (alu_hdata)
    );

    wb_hold_slot #(.DW(DW), .AW(AW)) u_mem_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (mem_valid),
        .load_addr_i  (mem_addr),
        .load_data_i  (mem_data),
        .drain_i      (grant_mem),
        .ready_o      (mem_ready),
        .hold_v_o     (mem_hv),
        .addr_o       (mem_haddr),
        .data_o       (mem_hdata)
    );

`ifdef WB_RR_ARB_EN
    logic last_grant_q, last_grant_d;

    // On a tie the slot that did not win last time goes next.
    assign mem_wins = ~alu_hv | (last_grant_q == REQ_ALU);

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_mem)      last_grant_d = REQ_MEM;
        else if (grant_alu) last_grant_d = REQ_ALU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= REQ_ALU;
        else        last_grant_q <= last_grant_d;
    end
`else
    assign mem_wins = 1'b1;
`endif

    assign grant_mem = mem_hv & mem_wins;
    assign grant_alu = alu_hv & ~grant_mem;
    assign any_grant = grant_mem | grant_alu;
    assign gaddr     = grant_mem ? mem_haddr : alu_haddr;
    assign gdata     = grant_mem ? mem_hdata : alu_hdata;

    always_comb begin
        wr_d    = any_grant & (gaddr != '0);
        addr3_d = addr3_q;
        data3_d = data3_q;
        if (any_grant) begin
            addr3_d = gaddr;
            data3_d = gdata;
        end
    end

    // Clear first, then set: a claim on the same edge is younger than the retiring write.
    always_comb begin
        busy_d = busy_q;
        if (any_grant && gaddr != '0)
            busy_d[gaddr] = 1'b0;
        if (claim_valid && claim_addr != '0)
            busy_d[claim_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr3_q <= '0;
            data3_q <= '0;
            busy_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            addr3_q <= addr3_d;
            data3_q <= data3_d;
            busy_q  <= busy_d;
        end
    end

    assign wr        = wr_q;
    assign addr3     = addr3_q;
    assign data3     = data3_q;
    assign busy_mask = busy_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: scoreboard of expected register-file writes plus a regfile model.
module tb_reg_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, claim_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_addr, mem_addr, claim_addr;
    logic [31:0] alu_data, mem_data;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;
    logic [31:0] busy_mask;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    logic [31:0] regs [32];

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .wr          (wr),
        .addr3       (addr3),
        .data3       (data3),
        .busy_mask   (busy_mask)
    );

    // Register file model: captures on the negedge while wr is high.
    always @(negedge clk) if (wr === 1'b1) regs[addr3] = data3;

    always @(negedge clk) begin
        if (mon_en && rst_n && wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got addr3=%0d data3=%h, required no write", addr3, data3);
            end else begin
                mon_e = exp_q.pop_front();
                if (addr3 !== mon_e.a || data3 !== mon_e.d) begin
                    errors++;
                    $display("FAIL wb_order: got addr3=%0d data3=%h, required addr3=%0d data3=%h",
                             addr3, data3, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (wr !== 1'b0)          begin errors++; $display("FAIL rst_wr: got %b required 0", wr); end
        checks++; if (addr3 !== 5'd0)       begin errors++; $display("FAIL rst_addr3: got %0d required 0", addr3); end
        checks++; if (data3 !== 32'd0)      begin errors++; $display("FAIL rst_data3: got %h required 0", data3); end
        checks++; if (busy_mask !== 32'd0)  begin errors++; $display("FAIL rst_busy: got %h required 0", busy_mask); end
        checks++; if (alu_ready !== 1'b1)   begin errors++; $display("FAIL rst_alu_ready: got %b required 1", alu_ready); end
        checks++; if (mem_ready !== 1'b1)   begin errors++; $display("FAIL rst_mem_ready: got %b required 1", mem_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_write();
        mon_en = 1'b0;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
        claim_valid = 1'b1; claim_addr = 5'd8;
        step();
        mem_addr = 5'd8; mem_data = 32'h88;
        claim_valid = 1'b0;
        step();
        mem_valid = 1'b0;
        checks++; if (wr !== 1'b1)          begin errors++; $display("FAIL rmw_pre_wr: got %b required 1", wr); end
        checks++; if (busy_mask[8] !== 1'b1) begin errors++; $display("FAIL rmw_pre_busy8: got %b required 1", busy_mask[8]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wr !== 1'b0)          begin errors++; $display("FAIL rmw_wr: got %b required 0", wr); end
        checks++; if (busy_mask !== 32'd0)  begin errors++; $display("FAIL rmw_busy: got %h required 0", busy_mask); end
        checks++; if (addr3 !== 5'd0)       begin errors++; $display("FAIL rmw_addr3: got %0d required 0", addr3); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rmw_after_wr[%0d]: got %b required 0", i, wr); end
        end
        checks++; if (regs[7] !== 32'd0) begin errors++; $display("FAIL rmw_reg7: got %h required 0", regs[7]); end
        checks++; if (regs[8] !== 32'd0) begin errors++; $display("FAIL rmw_reg8: got %h required 0", regs[8]); end
        mon_en = 1'b1;
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h55;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", alu_ready); end
        exp_q.push_back('{a: 5'd9, d: 32'h55});
        step();
        alu_valid = 1'b0;
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_wr_t: got %b required 0", wr); end
        step();
        checks++; if (wr !== 1'b1 || addr3 !== 5'd9 || data3 !== 32'h55) begin
            errors++; $display("FAIL single_port: got wr=%b addr3=%0d data3=%h required 1/9/00000055", wr, addr3, data3);
        end
        @(negedge clk);
        #1;
        checks++; if (regs[9] !== 32'h55) begin errors++; $display("FAIL single_reg9: got %h required 00000055", regs[9]); end
        step();
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_wr_end: got %b required 0", wr); end
    endtask

    task automatic test_simultaneous();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h22;
        exp_q.push_back('{a: 5'd4, d: 32'h22});
        exp_q.push_back('{a: 5'd3, d: 32'h11});
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL simul_alu_ready: got %b required 0", alu_ready); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL simul_mem_ready: got %b required 1", mem_ready); end
        step();
        checks++; if (wr !== 1'b1 || addr3 !== 5'd4) begin
            errors++; $display("FAIL simul_first: got wr=%b addr3=%0d required 1/4", wr, addr3);
        end
        step();
        checks++; if (wr !== 1'b1 || addr3 !== 5'd3 || data3 !== 32'h11) begin
            errors++; $display("FAIL simul_second: got wr=%b addr3=%0d data3=%h required 1/3/00000011", wr, addr3, data3);
        end
        step();
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL simul_idle: got %b required 0", wr); end
        checks++; if (regs[3] !== 32'h11 || regs[4] !== 32'h22) begin
            errors++; $display("FAIL simul_regs: got r3=%h r4=%h required 00000011/00000022", regs[3], regs[4]);
        end
    endtask

    task automatic test_zero_write();
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFF_FFFF;
        claim_valid = 1'b1; claim_addr = 5'd0;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b required 1", mem_ready); end
        step();
        mem_valid = 1'b0; claim_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL zero_wr[%0d]: got %b required 0", i, wr); end
            step();
        end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL zero_busy: got %h required 0", busy_mask); end
        checks++; if (regs[0] !== 32'd0)   begin errors++; $display("FAIL zero_reg0: got %h required 0", regs[0]); end
        checks++; if (mem_ready !== 1'b1)  begin errors++; $display("FAIL zero_drained: got %b required 1", mem_ready); end
    endtask

    task automatic test_scoreboard();
        claim_valid = 1'b1; claim_addr = 5'd5;
        step();
        claim_valid = 1'b0;
        checks++; if (busy_mask[5] !== 1'b1) begin errors++; $display("FAIL sb_claim: got %b required 1", busy_mask[5]); end
        mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'h5A5A;
        exp_q.push_back('{a: 5'd5, d: 32'h5A5A});
        step();
        mem_valid = 1'b0;
        claim_valid = 1'b1; claim_addr = 5'd5;
        step();
        claim_valid = 1'b0;
        checks++; if (wr !== 1'b1 || busy_mask[5] !== 1'b1) begin
            errors++; $display("FAIL sb_collide: got wr=%b busy5=%b required 1/1", wr, busy_mask[5]);
        end
        mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'hA5;
        exp_q.push_back('{a: 5'd5, d: 32'hA5});
        step();
        mem_valid = 1'b0;
        step();
        checks++; if (wr !== 1'b1 || busy_mask[5] !== 1'b0) begin
            errors++; $display("FAIL sb_clear: got wr=%b busy5=%b required 1/0", wr, busy_mask[5]);
        end
        step();
    endtask

    task automatic test_arbitration();
        logic [4:0] exp_a;
        mon_en = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA;
        mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 32'hB;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef WB_RR_ARB_EN
            exp_a = (i % 2 == 0) ? 5'd11 : 5'd10;
`else
            exp_a = 5'd11;
            checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL arb_alu_ready[%0d]: got %b required 0", i, alu_ready); end
`endif
            checks++; if (wr !== 1'b1 || addr3 !== exp_a) begin
                errors++; $display("FAIL arb_grant[%0d]: got wr=%b addr3=%0d required 1/%0d", i, wr, addr3, exp_a);
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (4) step();
        checks++; if (wr !== 1'b0 || alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            errors++; $display("FAIL arb_drain: got wr=%b alu_ready=%b mem_ready=%b required 0/1/1", wr, alu_ready, mem_ready);
        end
        mon_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        claim_valid = 1'b0; claim_addr = '0;

        test_reset();
        test_reset_mid_write();
        test_single_alu();
        test_simultaneous();
        test_zero_write();
        test_scoreboard();
        test_arbitration();

        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d pending writes required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
